scan_sequencer_param: RTL and testbench
=======================================

Name: scan_sequencer_param

Overview:
- Parametrised successor of the spectrogram-channel scan FSM.
- On an overflow trigger, steps a mux select through N_CH channel slots; slot 0 is the RTC slot, the rest are filter channels.
- Each slot lasts SLOT_LEN clocks, with a shift-load pulse on the first cycle of the slot and a downstream reset pulse at frame end.
- Adds a per-channel skip mask, continuous (free-running) mode, abort, busy status and a missed-trigger counter.

Parameters:
- N_CH, 16, number of slots per frame, including slot 0 (RTC); must be >= 2.
- SLOT_LEN, 12, clocks per slot; must be >= 2.
- CNT_W, 4, slot counter width; must satisfy 2^CNT_W >= SLOT_LEN.
- MISS_W, 8, missed-trigger counter width.
- SEL_W, localparam, $clog2(N_CH), selection width.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-low; 0 at a rising edge resets the block.
- ovf, in, 1, frame trigger; expected as a single-cycle pulse.
- cont, in, 1, continuous mode; when 1, a new frame starts immediately after FLUSH.
- abort, in, 1, ends the current frame early through FLUSH.
- ch_mask, in, N_CH, bit i = 1 means slot i is scanned; latched at frame start.
- selection, out, SEL_W, index of the active slot.
- sl, out, 1, shift/load pulse, high on the first cycle of every scanned slot.
- rst, out, 1, one-cycle downstream reset pulse at frame end.
- busy, out, 1, high in SCAN and FLUSH.
- slot_cnt, out, CNT_W, cycle index within the current slot.
- miss_cnt, out, MISS_W, saturating count of triggers ignored while busy.

Behaviour:
- State machine: IDLE, SCAN, FLUSH. Moore outputs, registered state; no combinational input-to-output path.
- Reset (reset = 0 at an edge), all registers cleared:
  - state = IDLE, selection = 0, slot_cnt = 0, mask_q = 0, miss_cnt = 0.
  - sl = 0, rst = 0, busy = 0.
  - Reset takes effect mid-frame as well; no rst pulse is issued on reset.
- IDLE:
  - Outputs: selection = 0, sl = 0, rst = 0, busy = 0, slot_cnt = 0.
  - If ovf = 1: latch mask_q <= ch_mask.
    - If ch_mask is nonzero: go to SCAN with selection = lowest set index and slot_cnt = 0.
    - If ch_mask = 0: go to FLUSH.
  - abort is ignored in IDLE.
- SCAN:
  - sl = 1 exactly when slot_cnt = 0.
  - slot_cnt increments by 1 each cycle.
  - At slot_cnt = SLOT_LEN-1:
    - slot_cnt wraps to 0.
    - selection advances to the next higher set bit of mask_q.
    - If no higher set bit exists, go to FLUSH.
  - Latency: ovf in cycle k gives SCAN with sl = 1 in cycle k+1.
  - Frame length: SLOT_LEN × popcount(mask_q) cycles of SCAN.
- abort in SCAN: abort = 1 in any SCAN cycle moves the block to FLUSH next cycle; it takes priority over slot advance.
- FLUSH (one cycle):
  - Outputs: rst = 1, sl = 0, busy = 1; selection holds its last value; slot_cnt = 0.
  - Next state: SCAN if cont = 1 and abort = 0, with mask re-latched from ch_mask (IDLE-style start, no ovf needed); otherwise IDLE.
  - In the cont restart with ch_mask = 0, the next state is FLUSH again.
- Missed triggers:
  - Each cycle with ovf = 1 while state is SCAN or FLUSH increments miss_cnt.
  - miss_cnt saturates at 2^MISS_W - 1 and clears only on reset.
- Mask changes during a frame have no effect until the next frame start.

Test Plan:
- Reset 0 for 2 cycles, then ovf pulse, ch_mask = 0xFFFF, cont = 0:
  - Required: sl pulses at cycles 1, 13, …, 181 after ovf, with selection 0..15 in order.
  - Required: rst = 1 at cycle 193, busy low from cycle 194.
- ch_mask = 0x8021, ovf pulse:
  - Required: selection visits 0, 5, 15 only, each held 12 cycles.
  - Required: rst at cycle 37 after ovf.
- ch_mask = 0x0000, ovf pulse: rst = 1 in the cycle after ovf, sl never high, back to IDLE.
- cont = 1, ch_mask = 0x0003:
  - Required: rst pulses every 25 cycles, with SCAN restarting on selection 0 and sl = 1 in the cycle after each rst, with no ovf.
- abort asserted at slot 3, slot_cnt = 5:
  - Required: FLUSH (rst = 1) next cycle, then IDLE.
  - Then 300 ovf pulses during later frames: miss_cnt saturates at 255.
- Reset driven low mid-slot 7:
  - Required: next cycle all outputs 0 and state IDLE, with no rst pulse.
  - Required: a following ovf starts a normal frame.

Source files
------------

// File: rtl/scan_sequencer_param.sv
// Frame scan sequencer: on a trigger, walks a mux select through the enabled
// channel slots (slot 0 = RTC), pulsing shift/load per slot and a downstream reset at frame end.
module scan_sequencer_param #(
  parameter  int N_CH     = 16,
  parameter  int SLOT_LEN = 12,
  parameter  int CNT_W    = 4,
  parameter  int MISS_W   = 8,
  localparam int SEL_W    = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ovf,
  input  logic              cont,
  input  logic              abort,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [SEL_W-1:0]  selection,
  output logic              sl,
  output logic              rst,
  output logic              busy,
  output logic [CNT_W-1:0]  slot_cnt,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [CNT_W-1:0]  r_slot_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [N_CH-1:0]   r_mask;
  logic [N_CH-1:0]   w_mask_nxt;
  logic [MISS_W-1:0] r_miss_cnt;

  logic [SEL_W-1:0]  w_first_idx;
  logic              w_mask_nz;
  logic [SEL_W-1:0]  w_next_idx;
  logic              w_has_next;
  logic              w_slot_end;
  logic              w_miss_sat;

  // Lowest enabled slot of the incoming mask, used at every frame start.
  always_comb begin
    w_first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) w_first_idx = SEL_W'(i);
    end
  end

  assign w_mask_nz = |ch_mask;

  // Next enabled slot strictly above the current one in the latched mask.
  always_comb begin
    w_next_idx = '0;
    w_has_next = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (SEL_W'(i) > r_sel)) begin
        w_next_idx = SEL_W'(i);
        w_has_next = 1'b1;
      end
    end
  end

  assign w_slot_end = (r_slot_cnt == CNT_W'(SLOT_LEN - 1));
  assign w_miss_sat = &r_miss_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_slot_cnt;
    w_mask_nxt  = r_mask;
    case (r_state)
      S_IDLE: begin
        w_sel_nxt = '0;
        w_cnt_nxt = '0;
        if (ovf) begin
          w_mask_nxt = ch_mask;
          if (w_mask_nz) begin
            w_state_nxt = S_SCAN;
            w_sel_nxt   = w_first_idx;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_SCAN: begin
        // abort wins over the slot advance and keeps the current selection
        if (abort) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end else if (w_slot_end) begin
          w_cnt_nxt = '0;
          if (w_has_next) w_sel_nxt = w_next_idx;
          else            w_state_nxt = S_FLUSH;
        end else begin
          w_cnt_nxt = r_slot_cnt + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        w_cnt_nxt = '0;
        if (cont && !abort) begin
          w_mask_nxt = ch_mask;
          if (w_mask_nz) begin
            w_state_nxt = S_SCAN;
            w_sel_nxt   = w_first_idx;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_slot_cnt <= '0;
      r_mask     <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_slot_cnt <= w_cnt_nxt;
      r_mask     <= w_mask_nxt;
      if (ovf && (r_state != S_IDLE) && !w_miss_sat) r_miss_cnt <= r_miss_cnt + MISS_W'(1);
    end
  end

  assign selection   = r_sel;
  assign slot_cnt    = r_slot_cnt;
  assign sl          = (r_state == S_SCAN) && (r_slot_cnt == '0);
  assign rst         = (r_state == S_FLUSH);
  assign busy        = (r_state != S_IDLE);
  assign miss_cnt    = r_miss_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_scan_sequencer_param.sv
// Bench for scan_sequencer_param: directed frame scenarios plus random traffic,
// checked cycle by cycle against a frame-plan reference model.
module tb_scan_sequencer_param;

  localparam int N_CH     = 16;
  localparam int SLOT_LEN = 12;
  localparam int CNT_W    = 4;
  localparam int MISS_W   = 8;
  localparam int SEL_W    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ovf;
  logic              cont;
  logic              abort;
  logic [N_CH-1:0]   ch_mask;
  logic [SEL_W-1:0]  selection;
  logic              sl;
  logic              rst;
  logic              busy;
  logic [CNT_W-1:0]  slot_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic [1:0]        o_dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // expected output word: {sel[3:0], sl, rst, busy, cnt[3:0]}
  logic [10:0] exp_q[$];
  logic [10:0] cur;
  int          m_miss;

  always #5 clk = ~clk;

  scan_sequencer_param #(
    .N_CH(N_CH), .SLOT_LEN(SLOT_LEN), .CNT_W(CNT_W), .MISS_W(MISS_W)
  ) dut (
    .clk(clk), .reset(reset), .ovf(ovf), .cont(cont), .abort(abort),
    .ch_mask(ch_mask), .selection(selection), .sl(sl), .rst(rst),
    .busy(busy), .slot_cnt(slot_cnt), .miss_cnt(miss_cnt),
    .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input int sel, input bit s, input bit r, input bit b, input int cnt);
    return {4'(sel), s, r, b, 4'(cnt)};
  endfunction

  // A frame is the list of enabled slots, SLOT_LEN cycles each, followed by one flush cycle.
  task automatic build_frame(input logic [N_CH-1:0] m, input logic [3:0] held_sel);
    int last;
    exp_q.delete();
    last = int'(held_sel);
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        for (int j = 0; j < SLOT_LEN; j++) exp_q.push_back(mk(i, j == 0, 1'b0, 1'b1, j));
        last = i;
      end
    end
    exp_q.push_back(mk(last, 1'b0, 1'b1, 1'b1, 0));
  endtask

  task automatic model_step();
    if (!reset) begin
      cur = '0;
      exp_q.delete();
      m_miss = 0;
    end else begin
      if (ovf && cur[4] && m_miss < 255) m_miss++;
      if (!cur[4]) begin
        if (ovf) begin
          build_frame(ch_mask, cur[10:7]);
          cur = exp_q.pop_front();
        end
      end else if (cur[5]) begin
        if (cont && !abort) begin
          build_frame(ch_mask, cur[10:7]);
          cur = exp_q.pop_front();
        end else begin
          cur = '0;
          exp_q.delete();
        end
      end else if (abort) begin
        cur = mk(int'(cur[10:7]), 1'b0, 1'b1, 1'b1, 0);
        exp_q.delete();
      end else begin
        cur = exp_q.pop_front();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("out", 32'({selection, sl, rst, busy, slot_cnt}), 32'(cur));
    check("miss", 32'(miss_cnt), 32'(m_miss));
  endtask

  // Pulse ovf, then count cycles until rst is seen; also record the order of sl slots.
  task automatic frame_measure(input logic [N_CH-1:0] m, input int max, output int n, output logic [31:0] vis);
    n = -1;
    vis = '0;
    ch_mask = m;
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    for (int i = 1; i <= max; i++) begin
      if (i > 1) tick();
      if (sl) vis = {vis[27:0], selection};
      if (rst) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_slot(input int s, input int c, input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (busy && !rst && selection == 4'(s) && slot_cnt == 4'(c)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      tick();
    end
  endtask

  initial begin
    int          n;
    logic [31:0] vis;
    bit          found;

    cur = '0;
    m_miss = 0;
    reset = 1'b0; ovf = 1'b0; cont = 1'b0; abort = 1'b0; ch_mask = '0;
    tick();
    tick();
    check("reset_state", 32'(o_dbg_state), 32'd0);
    check("reset_outs", 32'({selection, sl, rst, busy, slot_cnt, miss_cnt}), 32'd0);
    reset = 1'b1;
    tick();

    frame_measure(16'hFFFF, 400, n, vis);
    check("full_rst_cycle", 32'(n), 32'd193);
    tick();
    check("full_busy_low", 32'(busy), 32'd0);

    frame_measure(16'h8021, 100, n, vis);
    check("m8021_rst_cycle", 32'(n), 32'd37);
    check("m8021_visit", vis, 32'h05F);
    tick();

    frame_measure(16'h0000, 10, n, vis);
    check("m0_rst_cycle", 32'(n), 32'd1);
    check("m0_no_sl", vis, 32'd0);
    tick();
    check("m0_idle", 32'(busy), 32'd0);

    cont = 1'b1;
    frame_measure(16'h0003, 100, n, vis);
    check("cont_first", 32'(n), 32'd25);
    for (int k = 0; k < 2; k++) begin
      n = -1;
      for (int i = 1; i <= 100; i++) begin
        tick();
        if (rst) begin
          n = i;
          break;
        end
      end
      check("cont_period", 32'(n), 32'd25);
    end
    cont = 1'b0;
    drain(100);

    ch_mask = 16'hFFFF;
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    wait_slot(3, 5, 200, found);
    check("abort_reach", 32'(found), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rst", 32'(rst), 32'd1);
    tick();
    check("abort_idle", 32'(busy), 32'd0);

    cont = 1'b1;
    ch_mask = 16'h0F0F;
    ovf = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    ovf = 1'b0;
    check("miss_sat", 32'(miss_cnt), 32'd255);
    cont = 1'b0;
    drain(300);

    ch_mask = 16'hFFFF;
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    wait_slot(7, 4, 200, found);
    check("rstmid_reach", 32'(found), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rstmid_state", 32'(o_dbg_state), 32'd0);
    check("rstmid_outs", 32'({selection, sl, rst, busy, slot_cnt, miss_cnt}), 32'd0);
    frame_measure(16'h0101, 100, n, vis);
    check("rstmid_restart", 32'(n), 32'd25);
    tick();

    for (int i = 0; i < 4000; i++) begin
      ovf   = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) cont = ~cont;
      case ($urandom_range(0, 3))
        0:       ch_mask = '0;
        1:       ch_mask = 16'(1) << $urandom_range(0, N_CH - 1);
        default: ch_mask = 16'($urandom);
      endcase
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1; ovf = 1'b0; abort = 1'b0; cont = 1'b0;
    drain(300);
    check("end_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
